abc_accumulator: RTL and testbench



---
 rtl/abc_accumulator_pkg.sv | 15 +
 rtl/abc_accumulator.sv | 100 ++++++++++
 tb/tb_abc_accumulator.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/abc_accumulator_pkg.sv
// rtl/abc_accumulator_pkg.sv - shared A*B+C parameters and accumulator types
package ABC_parameter;

    localparam int lenght = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_t;

    function automatic int acc_width(input int frame_len);
        return 2 * lenght + $clog2(frame_len);
    endfunction

endpackage

// File: rtl/abc_accumulator.sv
// rtl/abc_accumulator.sv - sums FRAME_LEN multiply-add results into a valid/ready frame sum
module abc_accumulator
    import ABC_parameter::*;
#(
    parameter int  FRAME_LEN = 8,
    localparam int GUARD     = $clog2(FRAME_LEN),
    localparam int ACC_W     = acc_width(FRAME_LEN),
    localparam int CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2*lenght-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   sample_cnt
);

    acc_state_t       state;
    acc_state_t       state_next;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             accept;
    logic             take;
    logic             frame_end;
    logic             slot_free;

    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign frame_end = accept && (sample_cnt == CNT_W'(FRAME_LEN - 1));
    assign slot_free = !out_valid || out_ready;
    assign sum       = acc + ACC_W'(in_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (frame_end && !slot_free) state_next = HOLD;
            HOLD:  if (take) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state == ACCUM);
    end

    // A frame completing against a busy slot parks its sum in acc until the slot is taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            sample_cnt <= '0;
            out_sum    <= '0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (take) begin
                        out_valid <= 1'b0;
                    end
                    if (accept) begin
                        if (frame_end) begin
                            sample_cnt <= '0;
                            if (slot_free) begin
                                out_sum   <= sum;
                                out_valid <= 1'b1;
                                acc       <= '0;
                            end else begin
                                acc <= sum;
                            end
                        end else begin
                            acc        <= sum;
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (take) begin
                        out_sum <= acc;
                        acc     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    logic unused_guard;
    assign unused_guard = ^GUARD;

endmodule

// File: tb/tb_abc_accumulator.sv
// tb/tb_abc_accumulator.sv - directed self-checking bench for abc_accumulator
module tb_abc_accumulator;
    import ABC_parameter::*;

    localparam int FRAME_LEN = 4;
    localparam int ACC_W     = 18;
    localparam int CNT_W     = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [2*lenght-1:0] in_data;
    logic               in_valid;
    logic               in_ready;
    logic [ACC_W-1:0]   out_sum;
    logic               out_valid;
    logic               out_ready;
    logic [CNT_W-1:0]   sample_cnt;

    int checks = 0;
    int passes = 0;

    abc_accumulator #(.FRAME_LEN(FRAME_LEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2*lenght-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        out_ready = 1'b0;
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else passes++;
        checks++; if (out_sum !== 18'h0) $display("FAIL reset_out_sum got %h want 0", out_sum); else passes++;
        checks++; if (sample_cnt !== 2'd0) $display("FAIL reset_sample_cnt got %0d want 0", sample_cnt); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else passes++;
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        send(16'h0010);
        send(16'h0010);
        checks++; if (sample_cnt !== 2'd2) $display("FAIL midrst_cnt_before got %0d want 2", sample_cnt); else passes++;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got %0b want 0", out_valid); else passes++;
        checks++; if (out_sum !== 18'h0) $display("FAIL midrst_out_sum got %h want 0", out_sum); else passes++;
        checks++; if (sample_cnt !== 2'd0) $display("FAIL midrst_cnt got %0d want 0", sample_cnt); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got %0b want 1", in_ready); else passes++;
        for (int i = 0; i < 4; i++) send(16'h0001);
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'd4)
            $display("FAIL midrst_frame got valid=%0b sum=%h want valid=1 sum=4", out_valid, out_sum); else passes++;
        tick();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(16'h0001);
        send(16'h0002);
        send(16'h0003);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid got %0b want 0", out_valid); else passes++;
        checks++; if (sample_cnt !== 2'd3) $display("FAIL basic_cnt got %0d want 3", sample_cnt); else passes++;
        send(16'h0004);
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'h0000A)
            $display("FAIL basic_sum got valid=%0b sum=%h want valid=1 sum=0000a", out_valid, out_sum); else passes++;
        checks++; if (sample_cnt !== 2'd0) $display("FAIL basic_cnt_wrap got %0d want 0", sample_cnt); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_taken got %0b want 0", out_valid); else passes++;
    endtask

    task automatic test_max();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(16'hFFFF);
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'h3FFFC)
            $display("FAIL max_sum got valid=%0b sum=%h want valid=1 sum=3fffc", out_valid, out_sum); else passes++;
        tick();
    endtask

    task automatic test_back_to_back();
        int pulses;
        int ready_drops;
        int bad_pulses;
        pulses = 0; ready_drops = 0; bad_pulses = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            if (in_ready !== 1'b1) ready_drops++;
            tick();
            if (out_valid === 1'b1) begin
                pulses++;
                if (!((i == 3 || i == 7) && out_sum === 18'h00400)) bad_pulses++;
            end
        end
        in_valid = 1'b0;
        checks++; if (pulses != 2) $display("FAIL b2b_pulses got %0d want 2", pulses); else passes++;
        checks++; if (bad_pulses != 0) $display("FAIL b2b_pulse_pos got %0d bad want 0", bad_pulses); else passes++;
        checks++; if (ready_drops != 0) $display("FAIL b2b_in_ready got %0d drops want 0", ready_drops); else passes++;
        tick();
    endtask

    task automatic test_stall();
        int ready_drops;
        ready_drops = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'h0001);
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'd4)
            $display("FAIL stall_first got valid=%0b sum=%h want valid=1 sum=4", out_valid, out_sum); else passes++;
        for (int i = 0; i < 4; i++) begin
            if (in_ready !== 1'b1) ready_drops++;
            send(16'h0002);
        end
        checks++; if (ready_drops != 0) $display("FAIL stall_accum_ready got %0d drops want 0", ready_drops); else passes++;
        checks++; if (in_ready !== 1'b0) $display("FAIL stall_hold_ready got %0b want 0", in_ready); else passes++;
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'd4)
            $display("FAIL stall_held got valid=%0b sum=%h want valid=1 sum=4", out_valid, out_sum); else passes++;
        in_valid = 1'b1;
        in_data  = 16'h0055;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0 || out_sum !== 18'd4)
            $display("FAIL stall_ignore got ready=%0b sum=%h want ready=0 sum=4", in_ready, out_sum); else passes++;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'd8)
            $display("FAIL stall_second got valid=%0b sum=%h want valid=1 sum=8", out_valid, out_sum); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL stall_release_ready got %0b want 1", in_ready); else passes++;
        tick();
        checks++; if (out_valid !== 1'b0) $display("FAIL stall_drained got %0b want 0", out_valid); else passes++;
    endtask

    task automatic test_gaps();
        logic [CNT_W-1:0] exp_cnt [7];
        logic [15:0]      samples [4];
        int               errs;
        exp_cnt = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        samples = '{16'd5, 16'd7, 16'd9, 16'd11};
        errs = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = samples[i / 2];
            tick();
            if (sample_cnt !== exp_cnt[i]) errs++;
        end
        in_valid = 1'b0;
        checks++; if (errs != 0) $display("FAIL gaps_cnt got %0d wrong steps want 0", errs); else passes++;
        checks++; if (out_valid !== 1'b1 || out_sum !== 18'd32)
            $display("FAIL gaps_sum got valid=%0b sum=%h want valid=1 sum=32", out_valid, out_sum); else passes++;
        tick();
    endtask

    initial begin
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_basic();
        test_max();
        test_back_to_back();
        test_stall();
        test_gaps();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
